// File: rtl/mux_n_reg.sv
// rtl/mux_n_reg.sv - N-channel W-bit registered mux with valid/ready handshakes
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   d         flattened channel data, channel i at d[i*WIDTH +: WIDTH]
//   d_valid   per-channel valid
//   d_ready   per-channel ready, at most one bit high (the granted channel)
//   mode      0 = fixed select (cur_sel), 1 = round-robin from rr_ptr
//   select    channel index loaded into cur_sel on sel_load
//   sel_load  single-cycle strobe loading select
//   q         registered output word
//   q_valid   q holds a valid word
//   q_ready   downstream accepts q
//   q_chan    source channel of the word in q
//   sel_err   sticky: an out-of-range select was loaded
module mux_n_reg #(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] d,
    input  logic [CHANNELS-1:0]       d_valid,
    output logic [CHANNELS-1:0]       d_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          select,
    input  logic                      sel_load,
    output logic [WIDTH-1:0]          q,
    output logic                      q_valid,
    input  logic                      q_ready,
    output logic [SEL_W-1:0]          q_chan,
    output logic                      sel_err
);

    logic [SEL_W-1:0] cur_sel;
    logic [SEL_W-1:0] rr_ptr;

    logic             open;
    logic             gnt_any;
    logic [SEL_W-1:0] gnt;
    logic [SEL_W-1:0] rr_gnt;
    logic [SEL_W-1:0] rr_idx;
    logic             rr_found;
    logic [SEL_W-1:0] rr_next;
    logic [WIDTH-1:0] gnt_data;
    logic             xfer;
    logic             sel_legal;

    // The output register can take a new word when empty or draining this cycle.
    assign open = !q_valid || q_ready;

    // A grant exists only when some channel is valid, in either mode.
    assign gnt_any = |d_valid;

    // Round-robin: first valid channel at or after rr_ptr, wrapping.
    always_comb begin
        rr_found = 1'b0;
        rr_gnt   = '0;
        rr_idx   = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            rr_idx = SEL_W'((int'(rr_ptr) + k) % CHANNELS);
            if (!rr_found && d_valid[rr_idx]) begin
                rr_found = 1'b1;
                rr_gnt   = rr_idx;
            end
        end
    end

    assign gnt = mode ? rr_gnt : cur_sel;

    // Ready is also held low while in reset so nothing upstream sees a
    // handshake that the reset is about to discard.
    always_comb begin
        d_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (gnt_any && open && !rst && (gnt == SEL_W'(i)))
                d_ready[i] = 1'b1;
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (gnt == SEL_W'(i))
                gnt_data = d[i*WIDTH +: WIDTH];
        end
    end

    assign xfer = |(d_ready & d_valid);

    assign rr_next = (gnt == SEL_W'(CHANNELS - 1)) ? '0 : gnt + 1'b1;

    // Extra top bit keeps the compare meaningful when CHANNELS is a power of 2.
    assign sel_legal = {1'b0, select} < (SEL_W + 1)'(CHANNELS);

    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= '0;
            q_valid <= 1'b0;
            q_chan  <= '0;
            sel_err <= 1'b0;
            cur_sel <= '0;
            rr_ptr  <= '0;
        end else begin
            if (xfer) begin
                q       <= gnt_data;
                q_chan  <= gnt;
                q_valid <= 1'b1;
                if (mode)
                    rr_ptr <= rr_next;
            end else if (q_ready) begin
                q_valid <= 1'b0;
            end

            // The grant above already used the old cur_sel this cycle.
            if (sel_load) begin
                if (sel_legal)
                    cur_sel <= select;
                else
                    sel_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/mux_n_reg.md
Name: mux_n_reg

Overview:
- Parametrised N-channel, W-bit multiplexer with a registered output stage and valid/ready handshakes on every input and on the output.
- Generalises the 2:1 select primitive to arbitrary width and channel count.
- Adds a registered software-loaded select with illegal-index detection, and a round-robin mode.
- Used as the data-steering stage in front of the IP-under-test monitors, where channel switching must not corrupt or duplicate words.

Parameters:
- WIDTH, 8, data bits per channel.
- CHANNELS, 4, number of input channels; must be at least 2.
- SEL_W: localparam, not overridable; equals $clog2(CHANNELS).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset; synchronous, active-high.
- d  input  CHANNELS*WIDTH  flattened inputs; channel i occupies d[i*WIDTH +: WIDTH].
- d_valid  input  CHANNELS  per-channel valid.
- d_ready  output  CHANNELS  per-channel ready; at most one bit high.
- mode  input  1  0 = fixed select, 1 = round-robin.
- select  input  SEL_W  requested channel index for mode 0.
- sel_load  input  1  single-cycle strobe that loads select.
- q  output  WIDTH  registered output data.
- q_valid  output  1  q holds a valid word.
- q_ready  input  1  downstream accepts q.
- q_chan  output  SEL_W  source channel of the word in q.
- sel_err  output  1  sticky flag: an out-of-range select was loaded.

Behaviour:
- Reset (rst=1 at a clk edge): q=0, q_valid=0, q_chan=0, sel_err=0, internal cur_sel=0, rr_ptr=0. Reset wins over every other event in the same cycle, including an in-flight transfer, which is dropped.
- Output register empty or draining: open = !q_valid | q_ready.
- Grant channel g:
  - mode 0: g = cur_sel.
  - mode 1: g = first i with d_valid[i]=1, searching from rr_ptr upward and wrapping modulo CHANNELS.
  - If no channel is valid, there is no grant.
- d_ready[g] = open; all other d_ready bits are 0. d_ready is combinational from q_ready, mode, cur_sel, rr_ptr and d_valid.
- Transfer: d_valid[g] & d_ready[g] at an edge loads q <= d[g], q_chan <= g, q_valid <= 1. Latency is 1 cycle from input handshake to q_valid.
- Output drain: q_valid & q_ready with no new transfer clears q_valid. q and q_chan keep their last value.
- Throughput: one word per cycle when q_ready is held high. Simultaneous drain and transfer replaces q with no bubble.
- Backpressure: while q_valid=1 and q_ready=0, q and q_chan are held stable and all d_ready bits are 0.
- Select load (mode 0 and mode 1):
  - sel_load with select < CHANNELS sets cur_sel <= select at that edge; it takes effect on the next cycle.
  - A transfer in the same cycle as sel_load uses the old cur_sel.
  - sel_load with select >= CHANNELS (possible only when CHANNELS is not a power of 2) leaves cur_sel unchanged and sets sel_err=1. sel_err clears only on rst.
- Round-robin pointer (mode 1 only):
  - On a transfer, rr_ptr <= (g+1) mod CHANNELS; g = CHANNELS-1 wraps to 0.
  - rr_ptr is unchanged on cycles without a transfer and at all times in mode 0.
- Mode change takes effect combinationally on the grant. A word already in q is unaffected.
- No word is ever duplicated or lost. Each input handshake produces exactly one output handshake, unless rst intervenes.

Test Plan:
- Reset: assert rst for 2 cycles with all d_valid=1 -> q=0, q_valid=0, q_chan=0, sel_err=0, d_ready=0 during reset.
- Mode 0 select: WIDTH=8, CHANNELS=4. Load select=2; d[2]=0xA5 valid; q_ready=1 -> next cycle q=0xA5, q_chan=2, q_valid=1. d_ready=4'b0100 only.
- Backpressure: q_ready=0 with q_valid=1 for 3 cycles, d_valid[2] held -> q stable, d_ready=0. Release q_ready -> next word appears the following cycle, no duplication.
- Select switch mid-stream: sel_load select=1 in the same cycle as a channel-2 transfer -> that word has q_chan=2, and the next word has q_chan=1.
- Round-robin: mode=1, all four channels valid continuously, q_ready=1 -> q_chan sequence 0,1,2,3,0. With only channels 1 and 3 valid -> 1,3,1,3.
- Illegal select: CHANNELS=3, load select=3 -> sel_err=1, cur_sel unchanged; sel_err stays set until rst, then returns to 0.
